mac_weight_loader: RTL

MAC_WEIGHT_LOADER -- requirements
Module: mac_weight_loader

---
 rtl/mac_weight_loader.sv | 87 ++++++++
 1 files changed

// File: rtl/mac_weight_loader.sv
// Loads IC0 weight rows into the MAC array weight chain after a start pulse; rows pass through with zero latency.
// Backpressure: weight_rdy is high only while loading, and upstream stalls the load by holding weight_vld low.
module mac_weight_loader #(
  parameter int IC0 = 2,
  parameter int OC0 = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              weight_vld,
  input  logic [16*OC0-1:0] weight_dat,
  output logic              weight_rdy,
  output logic              weight_fifo_enq,
  output logic [16*OC0-1:0] weight_dat_chained_fifo_in,
  output logic              en_weight00,
  output logic              busy,
  output logic              done,
  output logic              weights_loaded
);

  localparam int CW = $clog2(IC0 + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   row_cnt;
  logic            fire;
  logic            first_row;
  logic            last_row;
  logic            start_acc;

  assign fire      = weight_vld && (state == LOAD);
  assign first_row = (row_cnt == '0);
  assign last_row  = (row_cnt == CW'(IC0 - 1));
  // start only counts in IDLE; starts seen in LOAD or FINISH are dropped
  assign start_acc = start && (state == IDLE);

  assign weight_fifo_enq            = fire;
  assign weight_dat_chained_fifo_in = weight_dat;
  assign en_weight00                = fire && first_row;

  always_comb begin
    state_nxt  = state;
    weight_rdy = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        weight_rdy = 1'b1;
        busy       = 1'b1;
        if (fire && last_row) state_nxt = FINISH;
      end
      FINISH: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      row_cnt        <= '0;
      weights_loaded <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start_acc) begin
        row_cnt        <= '0;
        weights_loaded <= 1'b0;
      end else begin
        if (fire) row_cnt <= row_cnt + CW'(1);
        if (state == FINISH) weights_loaded <= 1'b1;
      end
    end
  end

endmodule
